// File: rtl/dag_addr_gen.sv
// Data address generator: NREG sets of I/M/L/B registers producing the registered DM address.
// Supports linear pre-modify, linear or circular post-modify, and ureg load/readback over the bc bus.
module dag_addr_gen #(
  parameter int DMA_SIZE = 17,
  parameter int DMD_SIZE = 16,
  parameter int NREG     = 4,
  parameter int RW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps_dg_en,
  input  logic                ps_dg_pre,
  input  logic [RW-1:0]       ps_dg_ireg,
  input  logic [RW-1:0]       ps_dg_mreg,
  input  logic                ps_dg_wrt,
  input  logic                ps_dg_rd,
  input  logic [1:0]          ps_dg_rsel,
  input  logic [RW-1:0]       ps_dg_radd,
  input  logic [DMD_SIZE-1:0] bc_dg_dt,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic                dg_vld,
  output logic [DMD_SIZE-1:0] dg_bc_dt
);

  // Two extra bits keep I+M and B+L free of false wrap during the circular compare.
  localparam int TW = DMA_SIZE + 2;

  logic [DMA_SIZE-1:0] i_r [NREG];
  logic [DMA_SIZE-1:0] m_r [NREG];
  logic [DMA_SIZE-1:0] l_r [NREG];
  logic [DMA_SIZE-1:0] b_r [NREG];

  logic [DMA_SIZE-1:0] cur_i_s;
  logic [DMA_SIZE-1:0] cur_m_s;
  logic [DMA_SIZE-1:0] cur_l_s;
  logic [DMA_SIZE-1:0] cur_b_s;
  logic [DMA_SIZE-1:0] pre_add_s;
  logic [TW-1:0]       t_s;
  logic [TW-1:0]       len_s;
  logic [TW-1:0]       lo_s;
  logic [TW-1:0]       hi_s;
  logic [TW-1:0]       nxt_w_s;
  logic [DMA_SIZE-1:0] i_nxt_s;
  logic                nxt_unused_s;
  logic [DMA_SIZE-1:0] wr_zx_s;
  logic [DMA_SIZE-1:0] wr_sx_s;
  logic [DMD_SIZE-1:0] rd_val_s;

  assign wr_zx_s = {{(DMA_SIZE-DMD_SIZE){1'b0}}, bc_dg_dt};
  assign wr_sx_s = {{(DMA_SIZE-DMD_SIZE){bc_dg_dt[DMD_SIZE-1]}}, bc_dg_dt};

  // Access-side address arithmetic: pre-modify sum and post-modify next index.
  always_comb begin
    cur_i_s   = i_r[ps_dg_ireg];
    cur_m_s   = m_r[ps_dg_mreg];
    cur_l_s   = l_r[ps_dg_ireg];
    cur_b_s   = b_r[ps_dg_ireg];
    pre_add_s = cur_i_s + cur_m_s;
    t_s       = {2'b00, cur_i_s} + {{2{cur_m_s[DMA_SIZE-1]}}, cur_m_s};
    len_s     = {2'b00, cur_l_s};
    lo_s      = {2'b00, cur_b_s};
    hi_s      = lo_s + len_s;
    if (cur_l_s == {DMA_SIZE{1'b0}}) begin
      nxt_w_s = t_s;
    end else if ($signed(t_s) >= $signed(hi_s)) begin
      nxt_w_s = t_s - len_s;
    end else if ($signed(t_s) < $signed(lo_s)) begin
      nxt_w_s = t_s + len_s;
    end else begin
      nxt_w_s = t_s;
    end
  end

  assign i_nxt_s      = nxt_w_s[DMA_SIZE-1:0];
  assign nxt_unused_s = &{1'b0, nxt_w_s[TW-1:DMA_SIZE]};

  // ureg read multiplexer over the low bus-width bits of the selected register.
  always_comb begin
    rd_val_s = {DMD_SIZE{1'b0}};
    case (ps_dg_rsel)
      2'd0:    rd_val_s = i_r[ps_dg_radd][DMD_SIZE-1:0];
      2'd1:    rd_val_s = m_r[ps_dg_radd][DMD_SIZE-1:0];
      2'd2:    rd_val_s = l_r[ps_dg_radd][DMD_SIZE-1:0];
      2'd3:    rd_val_s = b_r[ps_dg_radd][DMD_SIZE-1:0];
      default: rd_val_s = {DMD_SIZE{1'b0}};
    endcase
  end

  // Register file: post-modify update first so a same-cycle ureg write to I overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        i_r[k] <= {DMA_SIZE{1'b0}};
        m_r[k] <= {DMA_SIZE{1'b0}};
        l_r[k] <= {DMA_SIZE{1'b0}};
        b_r[k] <= {DMA_SIZE{1'b0}};
      end
    end else begin
      if (ps_dg_en && !ps_dg_pre) begin
        i_r[ps_dg_ireg] <= i_nxt_s;
      end
      if (ps_dg_wrt) begin
        case (ps_dg_rsel)
          2'd0:    i_r[ps_dg_radd] <= wr_zx_s;
          2'd1:    m_r[ps_dg_radd] <= wr_sx_s;
          2'd2:    l_r[ps_dg_radd] <= wr_zx_s;
          2'd3:    b_r[ps_dg_radd] <= wr_zx_s;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs: DM address/valid and ureg read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dg_dm_add <= {DMA_SIZE{1'b0}};
      dg_vld    <= 1'b0;
      dg_bc_dt  <= {DMD_SIZE{1'b0}};
    end else begin
      dg_vld <= ps_dg_en;
      if (ps_dg_en) begin
        dg_dm_add <= ps_dg_pre ? pre_add_s : cur_i_s;
      end
      if (ps_dg_rd) begin
        dg_bc_dt <= rd_val_s;
      end
    end
  end

endmodule

// File: tb/tb_dag_addr_gen.sv
// Bench for dag_addr_gen: a vector table is fed cycle by cycle while address and readback
// expectations are queued at drive time and compared when the outputs appear.
module tb_dag_addr_gen;

  localparam logic [1:0] RI = 2'd0;
  localparam logic [1:0] RM = 2'd1;
  localparam logic [1:0] RL = 2'd2;
  localparam logic [1:0] RB = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        ps_dg_en;
  logic        ps_dg_pre;
  logic [1:0]  ps_dg_ireg;
  logic [1:0]  ps_dg_mreg;
  logic        ps_dg_wrt;
  logic        ps_dg_rd;
  logic [1:0]  ps_dg_rsel;
  logic [1:0]  ps_dg_radd;
  logic [15:0] bc_dg_dt;
  logic [16:0] dg_dm_add;
  logic        dg_vld;
  logic [15:0] dg_bc_dt;

  dag_addr_gen #(.DMA_SIZE(17), .DMD_SIZE(16), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps_dg_en(ps_dg_en), .ps_dg_pre(ps_dg_pre),
    .ps_dg_ireg(ps_dg_ireg), .ps_dg_mreg(ps_dg_mreg),
    .ps_dg_wrt(ps_dg_wrt), .ps_dg_rd(ps_dg_rd),
    .ps_dg_rsel(ps_dg_rsel), .ps_dg_radd(ps_dg_radd),
    .bc_dg_dt(bc_dg_dt),
    .dg_dm_add(dg_dm_add), .dg_vld(dg_vld), .dg_bc_dt(dg_bc_dt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        pre;
    logic [1:0]  ireg;
    logic [1:0]  mreg;
    logic        wrt;
    logic        rd;
    logic [1:0]  rsel;
    logic [1:0]  radd;
    logic [15:0] dt;
    logic [16:0] exp_add;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] add_q[$];
  logic [15:0] rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] last_add;
  logic [15:0] last_rd;

  function automatic vec_t mk(input logic en, input logic pre, input logic [1:0] ireg,
                              input logic [1:0] mreg, input logic wrt, input logic rd,
                              input logic [1:0] rsel, input logic [1:0] radd,
                              input logic [15:0] dt, input logic [16:0] ea, input logic [15:0] er);
    vec_t v;
    v.en = en; v.pre = pre; v.ireg = ireg; v.mreg = mreg; v.wrt = wrt; v.rd = rd;
    v.rsel = rsel; v.radd = radd; v.dt = dt; v.exp_add = ea; v.exp_rd = er;
    return v;
  endfunction

  function automatic void pw(input logic [1:0] rsel, input logic [1:0] radd, input logic [15:0] dt);
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, rsel, radd, dt, 17'h0, 16'h0));
  endfunction

  function automatic void pa(input logic pre, input logic [1:0] ireg, input logic [1:0] mreg,
                             input logic [16:0] ea);
    vecs.push_back(mk(1'b1, pre, ireg, mreg, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, ea, 16'h0));
  endfunction

  function automatic void pr(input logic [1:0] rsel, input logic [1:0] radd, input logic [15:0] er);
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, rsel, radd, 16'h0, 17'h0, er));
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [16:0] ea;
    logic [15:0] er;
    @(negedge clk);
    ps_dg_en = v.en; ps_dg_pre = v.pre; ps_dg_ireg = v.ireg; ps_dg_mreg = v.mreg;
    ps_dg_wrt = v.wrt; ps_dg_rd = v.rd; ps_dg_rsel = v.rsel; ps_dg_radd = v.radd;
    bc_dg_dt = v.dt;
    if (v.en) add_q.push_back(v.exp_add);
    if (v.rd) rd_q.push_back(v.exp_rd);
    @(posedge clk);
    #1;
    chk("vld", idx, 32'(dg_vld), 32'(v.en));
    if (dg_vld && add_q.size() > 0) begin
      ea = add_q.pop_front();
      chk("addr", idx, 32'(dg_dm_add), 32'(ea));
      last_add = ea;
    end else if (!dg_vld) begin
      if (add_q.size() > 0) void'(add_q.pop_front());
      chk("addr_hold", idx, 32'(dg_dm_add), 32'(last_add));
    end
    if (v.rd && rd_q.size() > 0) begin
      er = rd_q.pop_front();
      chk("rd_data", idx, 32'(dg_bc_dt), 32'(er));
      last_rd = er;
    end else begin
      chk("rd_hold", idx, 32'(dg_bc_dt), 32'(last_rd));
    end
  endtask

  initial begin
    // Post-reset: every register must read back zero.
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 4; r++)
        pr(2'(t), 2'(r), 16'h0000);
    // Linear post-modify.
    pw(RI, 2'd0, 16'h0010); pw(RM, 2'd1, 16'h0003); pw(RL, 2'd0, 16'h0000);
    pa(1'b0, 2'd0, 2'd1, 17'h00010); pa(1'b0, 2'd0, 2'd1, 17'h00013); pa(1'b0, 2'd0, 2'd1, 17'h00016);
    pr(RI, 2'd0, 16'h0019);
    // Circular buffer, forward then backward.
    pw(RB, 2'd0, 16'h0100); pw(RL, 2'd0, 16'h0004); pw(RI, 2'd0, 16'h0102); pw(RM, 2'd0, 16'h0001);
    pa(1'b0, 2'd0, 2'd0, 17'h00102); pa(1'b0, 2'd0, 2'd0, 17'h00103);
    pa(1'b0, 2'd0, 2'd0, 17'h00100); pa(1'b0, 2'd0, 2'd0, 17'h00101);
    pw(RM, 2'd0, 16'hFFFF); pw(RI, 2'd0, 16'h0100);
    pa(1'b0, 2'd0, 2'd0, 17'h00100); pa(1'b0, 2'd0, 2'd0, 17'h00103); pa(1'b0, 2'd0, 2'd0, 17'h00102);
    pr(RL, 2'd0, 16'h0004); pr(RB, 2'd0, 16'h0100);
    // Pre-modify wrap: reach I2=0x1FFFF through a linear post-modify by -1 from 0.
    pw(RI, 2'd2, 16'h0000); pw(RM, 2'd2, 16'hFFFF);
    pa(1'b0, 2'd2, 2'd2, 17'h00000);
    pw(RM, 2'd2, 16'h0002);
    pa(1'b1, 2'd2, 2'd2, 17'h00001); pa(1'b1, 2'd2, 2'd2, 17'h00001);
    pr(RI, 2'd2, 16'hFFFF);
    pa(1'b0, 2'd2, 2'd2, 17'h1FFFF);
    pr(RI, 2'd2, 16'h0001);
    // Access/write collision on I0: old value used, write wins over the update.
    pw(RL, 2'd0, 16'h0000); pw(RI, 2'd0, 16'h0020); pw(RM, 2'd0, 16'h0001);
    vecs.push_back(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, RI, 2'd0, 16'h0050, 17'h00020, 16'h0000));
    pa(1'b0, 2'd0, 2'd0, 17'h00050);
    // Read during write returns the old value; access and read together.
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, RI, 2'd0, 16'h1234, 17'h0, 16'h0051));
    vecs.push_back(mk(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, RI, 2'd0, 16'h0000, 17'h01235, 16'h1234));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, RM, 2'd3, 16'hFFFE, 17'h0, 16'h0000));
    pr(RM, 2'd3, 16'hFFFE);
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 17'h0, 16'h0));

    rst_n = 1'b0;
    ps_dg_en = 1'b0; ps_dg_pre = 1'b0; ps_dg_ireg = 2'd0; ps_dg_mreg = 2'd0;
    ps_dg_wrt = 1'b0; ps_dg_rd = 1'b0; ps_dg_rsel = 2'd0; ps_dg_radd = 2'd0;
    bc_dg_dt = 16'h0000;
    last_add = 17'h0; last_rd = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset with a request in flight: outputs clear without a clock edge.
    apply(mk(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, RI, 2'd0, 16'h0005, 17'h0, 16'h0), -1);
    apply(mk(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, RI, 2'd0, 16'h0000, 17'h00005, 16'h0005), -2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_vld", -3, 32'(dg_vld), 32'd0);
    chk("rst_addr", -3, 32'(dg_dm_add), 32'd0);
    chk("rst_rd", -3, 32'(dg_bc_dt), 32'd0);
    last_add = 17'h0; last_rd = 16'h0;
    add_q.delete(); rd_q.delete();
    @(negedge clk);
    ps_dg_en = 1'b0; ps_dg_rd = 1'b0; ps_dg_wrt = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
